boreal_xbar_rr: RTL
===================

# boreal_xbar_rr

Parametrised successor to the fixed two-master Boreal interconnect: an NM-master to NS-slave registered bus crossbar with round-robin arbitration, transaction locking, a per-master privilege mask and a slave-response timeout. It sits between all bus masters (CPU, DMA, gate) and the SoC slaves (ROM, SRAM, DMA, vector, AI mailbox, DVM, gate regs, ledger, privileged I/O). It replaces fixed gate-wins priority, which can starve the public bus, and it never hangs on a non-responding slave.

## Interface
- NM, 2: number of master ports (≥1)
- NS, 9: number of slave ports (≥1)
- SLV_BASE, boreal_pkg default map: NS×32 flattened base addresses, slave k at bits [32k+31:32k]
- SLV_MASK, boreal_pkg default map: NS×32 flattened decode masks; slave k hits when (addr & mask_k) == base_k
- PRIV_SLV, 9'h100: NS-bit mask of privileged slaves
- PRIV_MST, 2'b10: NM-bit mask of masters allowed to reach privileged slaves
- TIMEOUT, 64: cycles to wait for s_ack before error; 0 disables the timeout
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m_req  in  NM  per-master request; held high until m_ack
- m_wr  in  NM  per-master write (1) / read (0)
- m_addr  in  NM×32  per-master address
- m_wdata  in  NM×32  per-master write data
- m_strb  in  NM×4  per-master byte strobes
- m_rdata  out  NM×32  read data, valid with m_ack
- m_ack  out  NM  one-cycle completion pulse
- m_err  out  NM  error qualifier, valid with m_ack
- s_sel  out  NS  one-hot slave select
- s_wr  out  1  broadcast write flag
- s_addr  out  32  broadcast address
- s_wdata  out  32  broadcast write data
- s_strb  out  4  broadcast strobes
- s_rdata  in  NS×32  per-slave read data
- s_ack  in  NS  per-slave acknowledge
- grant  out  NM  one-hot owner of the current transaction, 0 in IDLE
- timeout_evt  out  1  one-cycle pulse when a timeout fires

## Operation
- FSM: IDLE, BUSY, RESP.
- IDLE: if any m_req is high, the arbiter picks the first requester at or after index ptr+1, wrapping modulo NM. The FSM latches wr, addr, wdata and strb plus the winner index g, then decodes. The lowest-index matching slave wins.
  - No slave matches → RESP with err=1.
  - Slave is in PRIV_SLV but g is not in PRIV_MST → RESP with err=1. s_sel never asserts.
  - Otherwise → BUSY.
- BUSY: s_sel[k]=1 and broadcast signals are driven from the latched values. The timeout counter increments each cycle.
  - s_ack[k]=1 → capture s_rdata[k], err=0, go to RESP.
  - Counter reaches TIMEOUT → err=1, rdata=0, timeout_evt pulses, go to RESP.
- RESP: m_ack[g]=1, m_err[g]=err, m_rdata[g]=captured data. All other masters read 0. ptr←g, then IDLE.
- Transaction lock: requests arriving and m_req changes are ignored outside IDLE. A master that drops m_req mid-transaction still gets its RESP pulse.
- s_ack on a non-selected slave is ignored. Its s_rdata is never muxed.
- Counter width is $clog2(TIMEOUT+1) and it clears on entry to BUSY.

## Timing
- Reset values: state IDLE, ptr=NM-1 (master 0 has first priority). All outputs are 0: m_ack, m_err, m_rdata, s_sel, s_wr, s_addr, s_wdata, s_strb, grant, timeout_evt.
- Request seen in IDLE at cycle 0 → s_sel at cycle 1.
- A slave acking in cycle 1 → m_ack at cycle 2. This is the minimum latency, and it is 3 cycles per transaction including IDLE.
- Decode or privilege error: m_ack with m_err at cycle 1.
- Timeout: s_sel is high for cycles 1..TIMEOUT. m_ack/m_err and timeout_evt are at cycle TIMEOUT+1.
- If s_ack arrives in the same cycle the counter hits TIMEOUT, the ack wins and there is no error.
- If a master holds m_req high after m_ack, it re-arbitrates in the following IDLE cycle. Other requesters get priority first.
- rst mid-transaction: the next cycle is IDLE with all outputs 0. No m_ack is issued for the aborted transfer.

## Structure
- boreal_pkg holds:
  - FSM state encoding
  - default SLV_BASE/SLV_MASK map (ROM 0x0000_0xxx, SRAM 0x0000_1xxx, 0x1000..0x1005_xxxx peripherals, privileged 0x2xxx_xxxx)
  - default PRIV_SLV
  - bus width constants (address and data 32, strobe 4)
- Sub-module boreal_rr_arbiter: NM-wide rotating-priority encoder, inputs req and ptr, outputs one-hot grant and index.

## Test plan
- Reset, then m0 reads 0x0000_1004 with SRAM acking in 1 cycle → s_sel[1] at cycle 1, m_ack[0] at cycle 2, data 0xDEADBEEF, m_err=0.
- m0 and m1 request continuously with zero-wait slaves → grants alternate 0,1,0,1. Neither master waits more than one transaction.
- m0 (not in PRIV_MST) writes 0x2000_0000 → m_ack[0]=1 and m_err[0]=1 at cycle 1, s_sel stays 0. m1 does the same → s_sel[8]=1.
- Access to 0x3000_0000 (unmapped) → m_err at cycle 1.
- Slave never acks with TIMEOUT=64 → timeout_evt and m_err at cycle 65. A subsequent request to the same slave is served normally.
- Assert rst in BUSY → all outputs 0 next cycle, no m_ack. A late s_ack from the aborted slave is ignored.

Source files
------------

// File: rtl/boreal_pkg.sv
// Shared types and constants for the Boreal round-robin crossbar.
// The default slave map describes the standard nine-slave SoC layout.
package boreal_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    localparam int unsigned DEF_NS = 9;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_t;

    // Slave order: ROM, SRAM, DMA, vector, AI mailbox, DVM, gate regs, ledger, privileged I/O.
    localparam logic [DEF_NS*AW-1:0] DEF_SLV_BASE = {
        32'h2000_0000, 32'h1005_0000, 32'h1004_0000, 32'h1003_0000, 32'h1002_0000,
        32'h1001_0000, 32'h1000_0000, 32'h0000_1000, 32'h0000_0000
    };

    localparam logic [DEF_NS*AW-1:0] DEF_SLV_MASK = {
        32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000
    };

    localparam logic [DEF_NS-1:0] DEF_PRIV_SLV = 9'h100;

endpackage

// File: rtl/boreal_rr_arbiter.sv
// Rotating-priority encoder: grants the first requester at or after ptr+1, wrapping.
module boreal_rr_arbiter #(
    parameter int unsigned NM = 2,
    parameter int unsigned IW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NM-1:0] gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int unsigned j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int unsigned i = 1; i <= NM; i++) begin
            j = (int'(ptr) + i) % NM;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/boreal_xbar_rr.sv
// NM-master to NS-slave registered crossbar with round-robin arbitration, transaction
// locking, privileged-slave protection and a slave-response timeout.
module boreal_xbar_rr
    import boreal_pkg::*;
#(
    parameter int unsigned         NM       = 2,
    parameter int unsigned         NS       = 9,
    parameter logic [NS*AW-1:0]    SLV_BASE = DEF_SLV_BASE,
    parameter logic [NS*AW-1:0]    SLV_MASK = DEF_SLV_MASK,
    parameter logic [NS-1:0]       PRIV_SLV = DEF_PRIV_SLV,
    parameter logic [NM-1:0]       PRIV_MST = NM'(2'b10),
    parameter int unsigned         TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NM-1:0]      m_req,
    input  logic [NM-1:0]      m_wr,
    input  logic [NM*AW-1:0]   m_addr,
    input  logic [NM*DW-1:0]   m_wdata,
    input  logic [NM*SW-1:0]   m_strb,
    output logic [NM*DW-1:0]   m_rdata,
    output logic [NM-1:0]      m_ack,
    output logic [NM-1:0]      m_err,
    output logic [NS-1:0]      s_sel,
    output logic               s_wr,
    output logic [AW-1:0]      s_addr,
    output logic [DW-1:0]      s_wdata,
    output logic [SW-1:0]      s_strb,
    input  logic [NS*DW-1:0]   s_rdata,
    input  logic [NS-1:0]      s_ack,
    output logic [NM-1:0]      grant,
    output logic               timeout_evt
);

    localparam int unsigned MW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned KW = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    state_t        state;
    logic [MW-1:0] ptr;
    logic [MW-1:0] g;
    logic [KW-1:0] slv;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;

    logic [NM-1:0] arb_gnt;
    logic [MW-1:0] arb_idx;
    logic          arb_valid;

    logic [AW-1:0] win_addr;
    logic          dec_hit;
    logic [KW-1:0] dec_idx;
    logic          priv_block;

    boreal_rr_arbiter #(
        .NM (NM),
        .IW (MW)
    ) u_arb (
        .req   (m_req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign win_addr = m_addr[arb_idx*AW +: AW];
    assign cnt_inc  = cnt + CW'(1);

    // Walk downwards so the lowest-index matching slave is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if ((win_addr & SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW]) begin
                dec_hit = 1'b1;
                dec_idx = KW'(k);
            end
        end
    end

    assign priv_block = PRIV_SLV[dec_idx] && !PRIV_MST[arb_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            ptr         <= MW'(NM - 1);
            g           <= '0;
            slv         <= '0;
            cnt         <= '0;
            m_rdata     <= '0;
            m_ack       <= '0;
            m_err       <= '0;
            s_sel       <= '0;
            s_wr        <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_strb      <= '0;
            grant       <= '0;
            timeout_evt <= 1'b0;
        end else begin
            m_ack       <= '0;
            m_err       <= '0;
            m_rdata     <= '0;
            timeout_evt <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (arb_valid) begin
                        g     <= arb_idx;
                        grant <= arb_gnt;
                        if (!dec_hit || priv_block) begin
                            state <= StResp;
                            m_ack <= arb_gnt;
                            m_err <= arb_gnt;
                        end else begin
                            state   <= StBusy;
                            slv     <= dec_idx;
                            cnt     <= '0;
                            s_sel   <= NS'(1) << dec_idx;
                            s_wr    <= m_wr[arb_idx];
                            s_addr  <= win_addr;
                            s_wdata <= m_wdata[arb_idx*DW +: DW];
                            s_strb  <= m_strb[arb_idx*SW +: SW];
                        end
                    end
                end
                StBusy: begin
                    if (s_ack[slv] || (TIMEOUT != 0 && cnt_inc == TO_VAL)) begin
                        state   <= StResp;
                        m_ack   <= grant;
                        s_sel   <= '0;
                        s_wr    <= 1'b0;
                        s_addr  <= '0;
                        s_wdata <= '0;
                        s_strb  <= '0;
                        // An ack landing on the timeout cycle still counts as success.
                        if (s_ack[slv]) begin
                            m_rdata[g*DW +: DW] <= s_rdata[slv*DW +: DW];
                        end else begin
                            m_err       <= grant;
                            timeout_evt <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                StResp: begin
                    ptr   <= g;
                    grant <= '0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
